// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch op codes, entry layout and tag constants (BRANCH_MISPREDICT_EN adds pred_pc)
package branch_pkg;

  // Tag value meaning "no producer": operand already holds its value
  localparam int TAG_INVALID = 0;

  // Default configuration widths used by the reference entry layout below
  localparam int BR_XLEN   = 32;
  localparam int BR_TAG_W  = 4;
  localparam int BR_RANK_W = 2;

  typedef enum logic [2:0] {
    BR_JAL  = 3'd0,
    BR_JALR = 3'd1,
    BR_BEQ  = 3'd2,
    BR_BNE  = 3'd3,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_op_e;

  // Station entry at the default widths; the station builds the same layout
  // from its own parameters so that it stays fully parametrised.
  typedef struct packed {
    logic                  valid;
    br_op_e                op;
    logic [BR_TAG_W-1:0]   target;
    logic [BR_XLEN-1:0]    val1;
    logic [BR_XLEN-1:0]    val2;
    logic [BR_TAG_W-1:0]   tag1;
    logic [BR_TAG_W-1:0]   tag2;
    logic [BR_XLEN-1:0]    imm;
    logic [BR_XLEN-1:0]    pc;
`ifdef BRANCH_MISPREDICT_EN
    logic [BR_XLEN-1:0]    pred_pc;
`endif
    logic [BR_RANK_W-1:0]  rank;
  } br_rs_entry_t;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational next-pc / taken / link computation for one branch
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_op_e            op_i,
  input  logic [XLEN-1:0]   val1_i,
  input  logic [XLEN-1:0]   val2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [XLEN-1:0]   next_pc_o,
  output logic [XLEN-1:0]   link_o,
  output logic              taken_o
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_sum;
  logic            cond;

  // Evaluate the branch condition and choose between target and fall-through
  always_comb begin
    pc_plus4  = pc_i + XLEN'(4);
    pc_target = pc_i + imm_i;
    jalr_sum  = val1_i + imm_i;
    cond      = 1'b0;
    case (op_i)
      BR_JAL:  cond = 1'b1;
      BR_JALR: cond = 1'b1;
      BR_BEQ:  cond = (val1_i == val2_i);
      BR_BNE:  cond = (val1_i != val2_i);
      BR_BLT:  cond = ($signed(val1_i) <  $signed(val2_i));
      BR_BGE:  cond = ($signed(val1_i) >= $signed(val2_i));
      BR_BLTU: cond = (val1_i <  val2_i);
      BR_BGEU: cond = (val1_i >= val2_i);
      default: cond = 1'b0;
    endcase
    link_o  = pc_plus4;
    taken_o = cond;
    if (op_i == BR_JALR) begin
      next_pc_o = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      next_pc_o = cond ? pc_target : pc_plus4;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch reservation station, oldest-ready issue; BRANCH_MISPREDICT_EN adds predicted-PC check
module branch_unit
  import branch_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int ROB_N    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAG_W-1:0]        in_target,
  input  logic [2:0]              in_op,
  input  logic [XLEN-1:0]         in_val1,
  input  logic [XLEN-1:0]         in_val2,
  input  logic [TAG_W-1:0]        in_tag1,
  input  logic [TAG_W-1:0]        in_tag2,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [ROB_N-1:0]        bc_valid,
  input  logic [ROB_N*TAG_W-1:0]  bc_tag,
  input  logic [ROB_N*XLEN-1:0]   bc_val,
`ifdef BRANCH_MISPREDICT_EN
  input  logic [XLEN-1:0]         in_pred_pc,
  output logic                    out_mispredict,
`endif
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_target,
  output logic [XLEN-1:0]         out_next_pc,
  output logic [XLEN-1:0]         out_link,
  output logic                    out_taken
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);

  typedef struct packed {
    logic              valid;
    br_op_e            op;
    logic [TAG_W-1:0]  target;
    logic [XLEN-1:0]   val1;
    logic [XLEN-1:0]   val2;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
`ifdef BRANCH_MISPREDICT_EN
    logic [XLEN-1:0]   pred_pc;
`endif
    logic [IDX_W-1:0]  rank;
  } rs_entry_t;

  typedef struct packed {
    logic             hit;
    logic [XLEN-1:0]  val;
  } snoop_t;

  // Search the broadcast bus for a tag; the lowest matching slot supplies the value
  function automatic snoop_t snoop(input logic [TAG_W-1:0] tag);
    snoop_t s;
    s.hit = 1'b0;
    s.val = '0;
    for (int b = ROB_N - 1; b >= 0; b--) begin
      if (tag != TAG_NONE && bc_valid[b] && bc_tag[b*TAG_W +: TAG_W] == tag) begin
        s.hit = 1'b1;
        s.val = bc_val[b*XLEN +: XLEN];
      end
    end
    return s;
  endfunction

  rs_entry_t               entries_q [RS_DEPTH];
  rs_entry_t               entries_d [RS_DEPTH];
  rs_entry_t               new_entry;
  snoop_t                  wake1 [RS_DEPTH];
  snoop_t                  wake2 [RS_DEPTH];
  snoop_t                  ins_s1;
  snoop_t                  ins_s2;
  logic [RS_DEPTH-1:0]     valid_vec;
  logic [RS_DEPTH-1:0]     ready_vec;
  logic                    issue_hit;
  logic [IDX_W-1:0]        issue_idx;
  logic [IDX_W-1:0]        issue_rank;
  logic [IDX_W-1:0]        free_idx;
  logic [CNT_W-1:0]        valid_cnt;
  logic                    ins_fire;

  logic [XLEN-1:0]         res_next_pc;
  logic [XLEN-1:0]         res_link;
  logic                    res_taken;

  logic                    out_valid_q;
  logic [TAG_W-1:0]        out_target_q;
  logic [XLEN-1:0]         out_next_pc_q;
  logic [XLEN-1:0]         out_link_q;
  logic                    out_taken_q;
`ifdef BRANCH_MISPREDICT_EN
  logic                    out_mispredict_q;
`endif

  // Per-entry occupancy, readiness and wakeup lookups from registered state
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid &&
                     entries_q[i].tag1 == TAG_NONE &&
                     entries_q[i].tag2 == TAG_NONE;
      wake1[i]     = snoop(entries_q[i].tag1);
      wake2[i]     = snoop(entries_q[i].tag2);
    end
  end

  // Space is judged only from registered valid bits, never from this cycle's issue
  assign in_ready = ~&valid_vec;
  assign ins_fire = in_valid && in_ready;

  // Pick the ready entry with the smallest rank (rank 0 is the oldest)
  always_comb begin
    issue_hit  = 1'b0;
    issue_idx  = '0;
    issue_rank = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready_vec[i] && (!issue_hit || entries_q[i].rank < issue_rank)) begin
        issue_hit  = 1'b1;
        issue_idx  = IDX_W'(i);
        issue_rank = entries_q[i].rank;
      end
    end
  end

  // Lowest-index free slot and current occupancy count
  always_comb begin
    free_idx  = '0;
    valid_cnt = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
      end else begin
        valid_cnt = valid_cnt + CNT_W'(1);
      end
    end
  end

  // Build the dispatched entry, picking up operands broadcast in the same cycle
  always_comb begin
    ins_s1           = snoop(in_tag1);
    ins_s2           = snoop(in_tag2);
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.op     = br_op_e'(in_op);
    new_entry.target = in_target;
    new_entry.val1   = ins_s1.hit ? ins_s1.val : in_val1;
    new_entry.tag1   = ins_s1.hit ? TAG_NONE   : in_tag1;
    new_entry.val2   = ins_s2.hit ? ins_s2.val : in_val2;
    new_entry.tag2   = ins_s2.hit ? TAG_NONE   : in_tag2;
    new_entry.imm    = in_imm;
    new_entry.pc     = in_pc;
`ifdef BRANCH_MISPREDICT_EN
    new_entry.pred_pc = in_pred_pc;
`endif
    // The newcomer is youngest; if an older entry leaves this edge it shifts down by one
    new_entry.rank   = IDX_W'(valid_cnt - CNT_W'(issue_hit));
  end

  // Next station contents: wakeup, free the issued entry, close the age gap, insert
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid && wake1[i].hit) begin
        entries_d[i].val1 = wake1[i].val;
        entries_d[i].tag1 = TAG_NONE;
      end
      if (entries_q[i].valid && wake2[i].hit) begin
        entries_d[i].val2 = wake2[i].val;
        entries_d[i].tag2 = TAG_NONE;
      end
      if (issue_hit && entries_q[i].valid && entries_q[i].rank > issue_rank) begin
        entries_d[i].rank = entries_q[i].rank - IDX_W'(1);
      end
    end
    if (issue_hit) begin
      entries_d[issue_idx].valid = 1'b0;
    end
    if (ins_fire) begin
      entries_d[free_idx] = new_entry;
    end
  end

  branch_resolve #(
    .XLEN (XLEN)
  ) u_resolve (
    .op_i      (entries_q[issue_idx].op),
    .val1_i    (entries_q[issue_idx].val1),
    .val2_i    (entries_q[issue_idx].val2),
    .imm_i     (entries_q[issue_idx].imm),
    .pc_i      (entries_q[issue_idx].pc),
    .next_pc_o (res_next_pc),
    .link_o    (res_link),
    .taken_o   (res_taken)
  );

  // Station and result registers; flush wins over insert and issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_target_q  <= '0;
      out_next_pc_q <= '0;
      out_link_q    <= '0;
      out_taken_q   <= 1'b0;
`ifdef BRANCH_MISPREDICT_EN
      out_mispredict_q <= 1'b0;
`endif
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      out_valid_q <= issue_hit;
      if (issue_hit) begin
        out_target_q  <= entries_q[issue_idx].target;
        out_next_pc_q <= res_next_pc;
        out_link_q    <= res_link;
        out_taken_q   <= res_taken;
`ifdef BRANCH_MISPREDICT_EN
        out_mispredict_q <= (res_next_pc != entries_q[issue_idx].pred_pc);
`endif
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_target  = out_target_q;
  assign out_next_pc = out_next_pc_q;
  assign out_link    = out_link_q;
  assign out_taken   = out_taken_q;
`ifdef BRANCH_MISPREDICT_EN
  assign out_mispredict = out_mispredict_q;
`endif

`ifndef SYNTHESIS
  // A dispatch offered while every entry is busy is dropped; flag it to the front end owner
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(in_valid && !in_ready))
        else $warning("branch_unit: dispatch request ignored while station full");
    end
  end
`endif

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised successor of the jump reservation station.
- Buffers JAL/JALR plus all six conditional branches in a RS_DEPTH-entry station, with two tagged operands per entry.
- Entries snoop the ROB broadcast for operand wakeup; the oldest ready entry issues with registered outputs.
- Results (next PC, link value, taken) go to the fetch redirect and the ROB writeback.

Parameters:
- RS_DEPTH, 4: station entries (power of 2, at least 2).
- XLEN, 32: datapath width.
- TAG_W, 4: ROB tag width; tag value 0 = TAG_INVALID (no dependency / no instruction).
- ROB_N, 8: number of broadcast slots snooped per cycle.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  squash every entry and any pending output.
- in_valid  in  1  dispatch request.
- in_ready  out  1  at least one free entry (from registered state).
- in_target  in  TAG_W  ROB tag of the branch.
- in_op  in  3  0 JAL, 1 JALR, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- in_val1/in_val2  in  XLEN each  operand values.
- in_tag1/in_tag2  in  TAG_W each  producer tags (0 = value valid).
- in_imm  in  XLEN  sign-extended immediate.
- in_pc  in  XLEN  instruction PC.
- bc_valid  in  ROB_N  broadcast slot valid.
- bc_tag  in  ROB_N*TAG_W  broadcast tags, slot i at bits [i*TAG_W +: TAG_W].
- bc_val  in  ROB_N*XLEN  broadcast values.
- out_valid  out  1  result valid for exactly one cycle.
- out_target  out  TAG_W  tag of the resolved branch.
- out_next_pc  out  XLEN  resolved next PC.
- out_link  out  XLEN  pc+4.
- out_taken  out  1  redirect taken.

Behaviour:
- Reset (async, any time): all entries invalid, age state cleared, out_valid=0, out_target=0, out_next_pc=0, out_link=0, out_taken=0, in_ready=1. Reset mid-operation discards everything.
- Insert: on a rising edge with in_valid && in_ready && !flush, the lowest-index free entry captures all inputs.
  - Operand capture checks the same-cycle broadcast: a tag matching a valid bc slot stores bc_val and sets the tag to 0.
- in_valid && !in_ready: request ignored and the station is unchanged. The simulation assertion fires.
- Wakeup: every valid entry with a nonzero tag compares it against every valid bc slot each edge. On a match, load the value and clear the tag. Multiple matching slots: the lowest slot index wins.
- Ready entry: valid, tag1==0, tag2==0. JAL is dispatched with both tags 0.
- Issue: at each edge, select the oldest ready entry as judged by state before this edge's insert and wakeup. Age is kept by a per-entry rank, where 0 = oldest.
  - The entry is freed; out_* are registered from it with out_valid=1.
  - No ready entry: out_valid=0, other outputs hold.
- Latency: an entry inserted with ready operands at edge k gives out_valid=1 after edge k+1. An entry woken at edge k issues at edge k+1.
- Arithmetic (all modulo 2^XLEN):
  - out_link = pc+4.
  - JAL: next_pc = pc+imm, taken=1.
  - JALR: next_pc = (val1+imm) with bit0 cleared, taken=1.
  - Branches: compare val1 against val2. BLT/BGE are signed, BLTU/BGEU unsigned. Taken gives pc+imm, else pc+4 with taken=0.
- Full: in_ready is derived only from the registered valid bits. An entry freed by issue at edge k is reusable from edge k+1.
- Flush: synchronous. At the edge, all entries are cleared and out_valid goes to 0. Flush has priority over insert and issue on the same edge.
- Rank update: on insert, the new entry takes rank = count of valid entries. On issue, ranks greater than the freed rank decrement.

Optional Feature:
- BRANCH_MISPREDICT_EN defined:
  - Adds input in_pred_pc (XLEN), stored per entry.
  - Adds output out_mispredict (1): out_next_pc != stored pred_pc, registered with out_valid, reset 0.
- Undefined: neither port exists, and there is no per-entry storage for the predicted PC.

Decomposition:
- Shared package branch_pkg: typedef br_op_e (8 codes), typedef br_rs_entry_t (valid, op, target, val1/2, tag1/2, imm, pc, rank), constant TAG_INVALID = 0.
- One sub-module, branch_resolve: purely combinational. Takes op/val1/val2/imm/pc and produces next_pc/taken/link. It is instantiated once, after selection.

Test Plan:
- BEQ inserted with val1=val2=5, tags 0, pc=0x100, imm=0x20 -> two edges later out_valid=1, next_pc=0x120, taken=1, link=0x104.
- BLT val1=0xFFFFFFFF, val2=1 -> taken, pc+imm. The same operands with BLTU -> not taken, next_pc=pc+4.
- JALR with tag1=3 pending, then bc slot 5 broadcasts tag 3, val 0x1001, imm=4 -> issues the edge after the broadcast with next_pc=0x1004.
- Fill all 4 entries with tag dependencies -> in_ready=0, and a fifth in_valid is ignored. Wake entries 2 and 0 (inserted order 0,1,2,3) in the same cycle -> entry 0 issues first, entry 2 the next edge.
- Flush asserted the same edge as in_valid and one ready entry -> no output, station empty, in_ready=1.
- Assert rst mid-issue -> all outputs 0 immediately, without a clock edge.
